// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared state type and default pattern for the serial pattern link
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        FIN  = 2'd3
    } seq_state_e;

    localparam logic [3:0] DEF_PATTERN_1011 = 4'b1011;

endpackage

// File: rtl/seq_pattern_tx_if.sv
// rtl/seq_pattern_tx_if.sv - control and serial-output bundle of the pattern transmitter
interface seq_pattern_tx_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 4,
    parameter int GAP_W = 3
);
    logic             start;
    logic             abort;
    logic             use_def;
    logic [PAT_W-1:0] pat;
    logic [CNT_W-1:0] reps;
    logic [GAP_W-1:0] gap;
    logic             x;
    logic             x_valid;
    logic             frame_start;
    logic             busy;
    logic             done;

    modport master (
        output start, abort, use_def, pat, reps, gap,
        input  x, x_valid, frame_start, busy, done
    );

    modport slave (
        input  start, abort, use_def, pat, reps, gap,
        output x, x_valid, frame_start, busy, done
    );
endinterface

// File: rtl/seq_down_cnt.sv
// rtl/seq_down_cnt.sv - loadable down-counter that holds at zero
module seq_down_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o,
    output logic         is_one_o
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load beats decrement; decrementing stops at zero so the count never wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o    = cnt_q;
    assign is_one_o = (cnt_q == W'(1));
endmodule

// File: rtl/seq_pattern_tx.sv
// rtl/seq_pattern_tx.sv - shifts a latched pattern out MSB-first with repeat count and idle gaps
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int               PAT_W       = 4,
    parameter int               CNT_W       = 4,
    parameter int               GAP_W       = 3,
    parameter logic [PAT_W-1:0] DEF_PATTERN = DEF_PATTERN_1011
) (
    input logic             clk,
    input logic             reset,
    seq_pattern_tx_if.slave bus
);
    localparam int               IDX_W   = $clog2(PAT_W);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);

    seq_state_e       state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [GAP_W-1:0] gap_q, gap_d;

    logic             bit_load, bit_dec, rep_load, rep_dec, gcnt_load, gcnt_dec;
    logic [IDX_W-1:0] bit_idx;
    logic [CNT_W-1:0] rep_cnt;
    logic [GAP_W-1:0] gcnt_val;
    logic             bit_one, rep_one, gcnt_one;
    logic             unused_cnt_bits;

    seq_down_cnt #(.W(IDX_W)) u_bit_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (bit_load),
        .load_val_i (IDX_TOP),
        .dec_i      (bit_dec),
        .cnt_o      (bit_idx),
        .is_one_o   (bit_one)
    );

    seq_down_cnt #(.W(CNT_W)) u_rep_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (rep_load),
        .load_val_i (bus.reps),
        .dec_i      (rep_dec),
        .cnt_o      (rep_cnt),
        .is_one_o   (rep_one)
    );

    seq_down_cnt #(.W(GAP_W)) u_gap_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (gcnt_load),
        .load_val_i (gap_q),
        .dec_i      (gcnt_dec),
        .cnt_o      (gcnt_val),
        .is_one_o   (gcnt_one)
    );

    assign unused_cnt_bits = ^{rep_cnt, gcnt_val, bit_one};

    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        gap_d     = gap_q;
        bit_load  = 1'b0;
        bit_dec   = 1'b0;
        rep_load  = 1'b0;
        rep_dec   = 1'b0;
        gcnt_load = 1'b0;
        gcnt_dec  = 1'b0;
        case (state_q)
            IDLE: begin
                // Start outranks abort here; abort is meaningless while idle.
                if (bus.start) begin
                    pat_d    = bus.use_def ? DEF_PATTERN : bus.pat;
                    gap_d    = bus.gap;
                    rep_load = 1'b1;
                    bit_load = 1'b1;
                    state_d  = (bus.reps == '0) ? FIN : SEND;
                end
            end
            SEND: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (bit_idx == '0) begin
                    rep_dec = 1'b1;
                    if (rep_one) begin
                        state_d = FIN;
                    end else if (gap_q == '0) begin
                        bit_load = 1'b1;
                    end else begin
                        state_d   = GAP;
                        gcnt_load = 1'b1;
                    end
                end else begin
                    bit_dec = 1'b1;
                end
            end
            GAP: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (gcnt_one) begin
                    state_d  = SEND;
                    bit_load = 1'b1;
                end else begin
                    gcnt_dec = 1'b1;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pat_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            gap_q   <= gap_d;
        end
    end

    assign bus.x           = (state_q == SEND) && pat_q[bit_idx];
    assign bus.x_valid     = (state_q == SEND);
    assign bus.frame_start = (state_q == SEND) && (bit_idx == IDX_TOP);
    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = (state_q == FIN);
endmodule
